// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM state encoding and port IDs for mem_arbiter.
package mem_arbiter_pkg;

    localparam int API_ADDR_WIDTH = 32;
    localparam int API_DATA_WIDTH = 32;

    // Wide enough for the largest legal access time (15 cycles).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE   = 2'd0,
        MEM_ARB_ACCESS = 2'd1,
        MEM_ARB_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        MEM_ARB_PORT_I = 1'b0,
        MEM_ARB_PORT_D = 1'b1
    } arb_port_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the instruction-fetch (I) or load/store (D) port access
// to the single-ported RAM, holds the chip select for RAM_LAT cycles and returns
// read data with a one-cycle ack.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate ties between the
// ports; otherwise D always wins a tie.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = API_ADDR_WIDTH,
    parameter int DATA_W  = API_DATA_WIDTH,
    parameter int RAM_LAT = 1              // legal range 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ack_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [3:0]        d_wr_mask_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic [3:0]        ram_wr_mask_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    arb_port_e         grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        mask_q, mask_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    arb_port_e         win;
    logic              in_access;
    logic              in_resp;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_port_e last_q;

    // Remember the most recent winner so the next tie goes to the other port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= MEM_ARB_PORT_D;
        end else if (state_q == MEM_ARB_IDLE && (i_req_i || d_req_i)) begin
            last_q <= win;
        end
    end
`endif

    // Two-input tie pick; a lone requester always wins.
    always_comb begin
        win = MEM_ARB_PORT_D;
        if (i_req_i && !d_req_i) begin
            win = MEM_ARB_PORT_I;
        end else if (i_req_i && d_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win = (last_q == MEM_ARB_PORT_D) ? MEM_ARB_PORT_I : MEM_ARB_PORT_D;
`else
            win = MEM_ARB_PORT_D;
`endif
        end
    end

    // State and request registers; every output is decoded from these.
    // NOTE: clocked state uses non-blocking (<=) so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MEM_ARB_IDLE;
            cnt_q   <= '0;
            grant_q <= MEM_ARB_PORT_D;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: grant in IDLE, count down in ACCESS, ack in RESP.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        case (state_q)
            MEM_ARB_IDLE: begin
                if (i_req_i || d_req_i) begin
                    grant_d = win;
                    cnt_d   = CNT_W'(RAM_LAT - 1);
                    state_d = MEM_ARB_ACCESS;
                    if (win == MEM_ARB_PORT_I) begin
                        // Instruction fetches are always reads.
                        addr_d  = i_addr_i;
                        wdata_d = '0;
                        mask_d  = '0;
                    end else begin
                        addr_d  = d_addr_i;
                        wdata_d = d_wdata_i;
                        mask_d  = d_wr_mask_i;
                    end
                end
            end
            MEM_ARB_ACCESS: begin
                if (cnt_q == '0) begin
                    // Writes return zero so the rdata outputs never show stale data.
                    rdata_d = (mask_q == 4'b0000) ? ram_rdata_i : '0;
                    state_d = MEM_ARB_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MEM_ARB_RESP: begin
                state_d = MEM_ARB_IDLE;
            end
            default: begin
                state_d = MEM_ARB_IDLE;
            end
        endcase
    end

    assign in_access = (state_q == MEM_ARB_ACCESS);
    assign in_resp   = (state_q == MEM_ARB_RESP);

    assign ram_en_o      = in_access;
    assign ram_addr_o    = in_access ? addr_q  : '0;
    assign ram_wdata_o   = in_access ? wdata_q : '0;
    assign ram_wr_mask_o = in_access ? mask_q  : 4'b0000;

    assign i_ack_o   = in_resp && (grant_q == MEM_ARB_PORT_I);
    assign d_ack_o   = in_resp && (grant_q == MEM_ARB_PORT_D);
    assign i_rdata_o = i_ack_o ? rdata_q : '0;
    assign d_rdata_o = d_ack_o ? rdata_q : '0;

endmodule
